// File: rtl/fp_credit_buffer.sv
// Credit-based result buffer around a fixed-latency FP pipeline without backpressure.
// Optional FP_CREDIT_BUFFER_RES_ERR_EN adds the inf/NaN result flag (o_res_err, o_err).
module fp_credit_buffer #(
    parameter int FLEN    = 64,
    parameter int NE      = 11,
    parameter int LATENCY = 16,
    parameter int DEPTH   = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_arg_vld,
    output logic            o_arg_rdy,
    input  logic [FLEN-1:0] i_a,
    input  logic [FLEN-1:0] i_b,
    input  logic [FLEN-1:0] i_c,
    output logic            o_pipe_arg_vld,
    output logic [FLEN-1:0] o_pipe_a,
    output logic [FLEN-1:0] o_pipe_b,
    output logic [FLEN-1:0] o_pipe_c,
    input  logic            i_pipe_res_vld,
    input  logic [FLEN-1:0] i_pipe_res,
    output logic            o_res_vld,
    input  logic            i_res_rdy,
    output logic [FLEN-1:0] o_res,
    output logic            o_busy,
    output logic            o_proto_err
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
    ,
    output logic            o_res_err,
    output logic            o_err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
    localparam int FW = FLEN + 1;
`else
    localparam int FW = FLEN;
`endif

    if (LATENCY < 1 || DEPTH < 2 || NE < 1 || NE > FLEN - 1) begin : g_cfg_err
        $error("fp_credit_buffer: illegal parameter set");
    end

    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_occ;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [FW-1:0] r_mem [DEPTH];
    logic          r_proto_err;

    logic [CW:0]   w_used;
    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [FW-1:0] w_wdata;
    logic [FW-1:0] w_head;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both in-flight operations and stored results.
    assign w_used    = {1'b0, r_inflight} + {1'b0, r_occ};
    assign o_arg_rdy = !i_rst && (w_used != (CW+1)'(DEPTH));
    assign o_busy    = (w_used != '0);
    assign o_res_vld = (r_occ != '0);

    assign w_accept = i_arg_vld & o_arg_rdy;
    assign w_pop    = o_res_vld & i_res_rdy;
    assign w_push   = i_pipe_res_vld & (r_inflight != '0);
    assign w_drop   = i_pipe_res_vld & (r_inflight == '0);

    assign o_pipe_arg_vld = w_accept;
    assign o_pipe_a       = i_a;
    assign o_pipe_b       = i_b;
    assign o_pipe_c       = i_c;

`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
    assign w_wdata = {(&i_pipe_res[FLEN-2 -: NE]), i_pipe_res};
`else
    assign w_wdata = i_pipe_res;
`endif

    assign w_head      = r_mem[r_rd_ptr];
    assign o_res       = w_head[FLEN-1:0];
    assign o_proto_err = r_proto_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight  <= '0;
            r_occ       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept && !w_push)
                r_inflight <= r_inflight + CW'(1);
            else if (!w_accept && w_push)
                r_inflight <= r_inflight - CW'(1);
            if (w_push && !w_pop)
                r_occ <= r_occ + CW'(1);
            else if (!w_push && w_pop)
                r_occ <= r_occ - CW'(1);
            if (w_push)
                r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= f_next(r_rd_ptr);
            if (w_drop)
                r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_wdata;
    end

`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
    logic r_err;

    assign o_res_err = o_res_vld & w_head[FLEN];
    assign o_err     = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err <= 1'b0;
        else if (w_pop && w_head[FLEN])
            r_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fp_credit_buffer.sv
// Bench for fp_credit_buffer: delay-line stub pipeline, queue-based reference model.
module tb_fp_credit_buffer;

    localparam int FLEN  = 64;
    localparam int NE    = 11;
    localparam int LAT   = 4;
    localparam int DEPTH = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            arg_vld;
    logic            arg_rdy;
    logic [FLEN-1:0] a, b, c;
    logic            pipe_arg_vld;
    logic [FLEN-1:0] pipe_a, pipe_b, pipe_c;
    logic            pipe_res_vld;
    logic [FLEN-1:0] pipe_res;
    logic            res_vld;
    logic            res_rdy;
    logic [FLEN-1:0] res;
    logic            busy;
    logic            proto_err;
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
    logic            res_err;
    logic            err;
`endif
    logic            force_vld;
    logic [FLEN-1:0] force_d;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [FLEN-1:0] m_inf_d[$];
    int              m_inf_t[$];
    logic [FLEN-1:0] m_fifo[$];
    bit              m_perr;
    bit              m_err;

    always #5 clk = ~clk;

    fp_credit_buffer #(
        .FLEN(FLEN), .NE(NE), .LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_arg_vld(arg_vld),
        .o_arg_rdy(arg_rdy),
        .i_a(a),
        .i_b(b),
        .i_c(c),
        .o_pipe_arg_vld(pipe_arg_vld),
        .o_pipe_a(pipe_a),
        .o_pipe_b(pipe_b),
        .o_pipe_c(pipe_c),
        .i_pipe_res_vld(pipe_res_vld),
        .i_pipe_res(pipe_res),
        .o_res_vld(res_vld),
        .i_res_rdy(res_rdy),
        .o_res(res),
        .o_busy(busy),
        .o_proto_err(proto_err)
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
        ,
        .o_res_err(res_err),
        .o_err(err)
`endif
    );

    // Stub pipeline: pipe_a delayed by LAT cycles, flushed by rst.
    logic [LAT-1:0]  sr_v;
    logic [FLEN-1:0] sr_d [LAT];

    always_ff @(posedge clk) begin
        if (rst) sr_v <= '0;
        else     sr_v <= {sr_v[LAT-2:0], pipe_arg_vld};
        sr_d[0] <= pipe_a;
        for (int i = 1; i < LAT; i++) sr_d[i] <= sr_d[i-1];
    end

    assign pipe_res_vld = sr_v[LAT-1] | force_vld;
    assign pipe_res     = force_vld ? force_d : sr_d[LAT-1];

    function automatic bit m_rdy();
        return !rst && (m_inf_d.size() + m_fifo.size() < DEPTH);
    endfunction

    function automatic bit m_busy();
        return (m_inf_d.size() + m_fifo.size()) != 0;
    endfunction

    function automatic bit is_err(input logic [FLEN-1:0] v);
        return v[62:52] == 11'h7FF;
    endfunction

    // Advance one clock edge and apply the same transaction to the model.
    task automatic tick();
        bit acc, pop, push, perr;
        logic [FLEN-1:0] av;
        acc  = arg_vld && m_rdy();
        av   = a;
        pop  = (m_fifo.size() > 0) && res_rdy;
        push = (m_inf_d.size() > 0) && (m_inf_t[0] == cyc);
        perr = force_vld && (m_inf_d.size() == 0);
        @(posedge clk);
        if (rst) begin
            m_inf_d.delete();
            m_inf_t.delete();
            m_fifo.delete();
            m_perr = 0;
            m_err  = 0;
        end else begin
            if (pop) begin
                if (is_err(m_fifo[0])) m_err = 1;
                void'(m_fifo.pop_front());
            end
            if (push) begin
                m_fifo.push_back(m_inf_d.pop_front());
                void'(m_inf_t.pop_front());
            end
            if (acc) begin
                m_inf_d.push_back(av);
                m_inf_t.push_back(cyc + LAT);
            end
            if (perr) m_perr = 1;
        end
        cyc++;
        #2;
    endtask

    task automatic test_reset();
        rst = 1; arg_vld = 0; res_rdy = 0; force_vld = 0;
        a = '0; b = '0; c = '0; force_d = '0;
        #1;
        checks++;
        if (arg_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rst_arg_rdy got=%b exp=0", arg_rdy);
        end
        tick(); tick();
        rst = 0;
        #1;
        checks++;
        if (arg_rdy !== 1'b1 || res_vld !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0) begin
            failures++;
            $display("FAIL post_rst rdy/vld/busy/perr got=%b%b%b%b exp=1000",
                     arg_rdy, res_vld, busy, proto_err);
        end
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
        checks++;
        if (res_err !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_err got=%b%b exp=00", res_err, err);
        end
`endif
    endtask

    task automatic test_single();
        arg_vld = 1; res_rdy = 1; a = 64'h3FF0_0000_0000_0000;
        b = 64'h1; c = 64'h2;
        #1;
        checks++;
        if (pipe_arg_vld !== 1'b1 || pipe_a !== a || pipe_b !== b || pipe_c !== c) begin
            failures++;
            $display("FAIL single_pass got=%b %h exp=1 %h", pipe_arg_vld, pipe_a, a);
        end
        tick();
        arg_vld = 0; a = '0;
        for (int k = 1; k <= LAT + 2; k++) begin
            #1;
            checks++;
            if (res_vld !== (k == LAT + 1) || busy !== (k <= LAT + 1)) begin
                failures++;
                $display("FAIL single_timing k=%0d vld=%b busy=%b exp_vld=%b exp_busy=%b",
                         k, res_vld, busy, k == LAT + 1, k <= LAT + 1);
            end
            if (k == LAT + 1) begin
                checks++;
                if (res !== 64'h3FF0_0000_0000_0000) begin
                    failures++;
                    $display("FAIL single_res got=%h exp=3ff0000000000000", res);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int n_out = 0, first = -1, last = -1;
        res_rdy = 1;
        for (int i = 0; i < 20 + LAT + 6; i++) begin
            arg_vld = (i < 20);
            a = (i < 20) ? $realtobits(real'(i + 1)) : '0;
            #1;
            if (i < 20) begin
                checks++;
                if (arg_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_rdy i=%0d got=%b exp=1", i, arg_rdy);
                end
            end
            if (res_vld === 1'b1) begin
                checks++;
                if (res !== $realtobits(real'(n_out + 1))) begin
                    failures++;
                    $display("FAIL b2b_res n=%0d got=%h exp=%h",
                             n_out, res, $realtobits(real'(n_out + 1)));
                end
                if (first < 0) first = i;
                last = i;
                n_out++;
            end
            tick();
        end
        checks++;
        if (n_out != 20 || last - first != 19) begin
            failures++;
            $display("FAIL b2b_count got=%0d span=%0d exp=20 span=19", n_out, last - first);
        end
    endtask

    task automatic test_stall();
        int n_acc = 0;
        logic [FLEN-1:0] exp_q[$];
        arg_vld = 1; res_rdy = 0;
        for (int i = 0; i < 16; i++) begin
            a = 64'd100 + 64'(i);
            #1;
            if (pipe_arg_vld === 1'b1) n_acc++;
            tick();
        end
        #1;
        checks++;
        if (n_acc != DEPTH || arg_rdy !== 1'b0 || res_vld !== 1'b1) begin
            failures++;
            $display("FAIL stall_fill acc=%0d rdy=%b vld=%b exp=%0d 0 1",
                     n_acc, arg_rdy, res_vld, DEPTH);
        end
        arg_vld = 0; res_rdy = 1;
        #1;
        checks++;
        if (res !== 64'd100) begin
            failures++;
            $display("FAIL stall_head got=%h exp=%h", res, 64'd100);
        end
        tick();
        #1;
        checks++;
        if (arg_rdy !== 1'b1) begin
            failures++;
            $display("FAIL stall_credit got=%b exp=1", arg_rdy);
        end
        arg_vld = 1; a = 64'd200;
        #1;
        checks++;
        if (pipe_arg_vld !== 1'b1 || res !== 64'd101) begin
            failures++;
            $display("FAIL stall_acc_pop got=%b %h exp=1 %h", pipe_arg_vld, res, 64'd101);
        end
        tick();
        res_rdy = 0; a = 64'd201;
        #1;
        tick();
        arg_vld = 0;
        #1;
        checks++;
        if (arg_rdy !== 1'b0) begin
            failures++;
            $display("FAIL stall_refill got=%b exp=0", arg_rdy);
        end
        exp_q = '{64'd102, 64'd103, 64'd104, 64'd105, 64'd200, 64'd201};
        res_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (res_vld === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || res !== exp_q[0]) begin
                    failures++;
                    $display("FAIL stall_drain got=%h exp=%h", res,
                             exp_q.size() ? exp_q[0] : 64'hX);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_left got=%0d busy=%b exp=0 0", exp_q.size(), busy);
        end
    endtask

`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
    task automatic test_res_err();
        logic [FLEN-1:0] vals[3];
        bit exp_e[3];
        vals = '{64'h7FF0_0000_0000_0000, 64'h7FF1_2345_6789_ABCD, 64'h4000_0000_0000_0000};
        exp_e = '{1, 1, 0};
        res_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            arg_vld = 1; a = vals[i];
            #1;
            tick();
        end
        arg_vld = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            #1;
            tick();
        end
        res_rdy = 1;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (res_err !== exp_e[j] || err !== (j > 0) || res !== vals[j]) begin
                failures++;
                $display("FAIL res_err j=%0d got=%b %b %h exp=%b %b %h",
                         j, res_err, err, res, exp_e[j], j > 0, vals[j]);
            end
            tick();
        end
        res_rdy = 0;
        #1;
        checks++;
        if (err !== 1'b1 || res_err !== 1'b0) begin
            failures++;
            $display("FAIL err_hold got=%b %b exp=1 0", err, res_err);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            arg_vld = ($urandom_range(0, 3) != 0);
            res_rdy = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 149) == 0);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a[62:52] = 11'h7FF;
            #1;
            checks++;
            if (arg_rdy !== m_rdy() || res_vld !== (m_fifo.size() > 0) ||
                busy !== m_busy() || proto_err !== m_perr ||
                pipe_arg_vld !== (arg_vld && m_rdy())) begin
                failures++;
                $display("FAIL rand_ctl i=%0d rdy=%b vld=%b busy=%b perr=%b exp=%b%b%b%b",
                         i, arg_rdy, res_vld, busy, proto_err,
                         m_rdy(), m_fifo.size() > 0, m_busy(), m_perr);
            end
            if (m_fifo.size() > 0) begin
                checks++;
                if (res !== m_fifo[0]) begin
                    failures++;
                    $display("FAIL rand_res i=%0d got=%h exp=%h", i, res, m_fifo[0]);
                end
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
                checks++;
                if (res_err !== is_err(m_fifo[0]) || err !== m_err) begin
                    failures++;
                    $display("FAIL rand_err i=%0d got=%b %b exp=%b %b",
                             i, res_err, err, is_err(m_fifo[0]), m_err);
                end
`endif
            end
            tick();
        end
        rst = 0; arg_vld = 0; res_rdy = 1;
        for (int i = 0; i < LAT + DEPTH + 4; i++) begin
            #1;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        arg_vld = 1; res_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            a = 64'd300 + 64'(i);
            #1;
            tick();
        end
        arg_vld = 0; rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (res_vld !== 1'b0 || busy !== 1'b0 || arg_rdy !== 1'b1 || proto_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst vld/busy/rdy/perr got=%b%b%b%b exp=0010",
                     res_vld, busy, arg_rdy, proto_err);
        end
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_err got=%b exp=0", err);
        end
`endif
        force_vld = 1; force_d = 64'hDEAD_BEEF_0000_0001;
        tick();
        force_vld = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (proto_err !== 1'b1 || res_vld !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_drop i=%0d perr=%b vld=%b busy=%b exp=1 0 0",
                         i, proto_err, res_vld, busy);
            end
            tick();
        end
        rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL perr_clear got=%b exp=0", proto_err);
        end
    endtask

    task automatic test_idle_perr();
        arg_vld = 0; res_rdy = 1;
        #1;
        tick();
        force_vld = 1; force_d = 64'h3FF0_0000_0000_0000;
        #1;
        tick();
        force_vld = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (proto_err !== 1'b1 || res_vld !== 1'b0 || busy !== 1'b0 || arg_rdy !== 1'b1) begin
                failures++;
                $display("FAIL idle_perr i=%0d perr=%b vld=%b busy=%b rdy=%b exp=1 0 0 1",
                         i, proto_err, res_vld, busy, arg_rdy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
`ifdef FP_CREDIT_BUFFER_RES_ERR_EN
        test_res_err();
`endif
        test_random();
        test_reset_mid();
        test_idle_perr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
